// File: rtl/v30mz_bus_responder.sv
// Bus target for a V30MZ-style initiator: 16-bit word RAM plus 16 byte-wide IO
// registers, acknowledged with an active-low readyb after a fixed number of wait states.
module v30mz_bus_responder #(
  parameter int WAIT_STATES   = 1,
  parameter int MEM_ADDR_BITS = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] address_in,
  input  logic [3:0]  bus_status,
  input  logic        bus_upper_byte_enable,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        readyb,
  output logic [1:0]  state_dbg
);

  // Handshake: a transaction is captured at any edge in IDLE where bus_status != 4'hf;
  // readyb is low for exactly one cycle (ACK) to complete it, and write data commits
  // at the edge that leaves ACK.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] CMD_IDLE = 4'hf;
  localparam logic [3:0] CMD_MRD  = 4'b1001;
  localparam logic [3:0] CMD_MWR  = 4'b1010;
  localparam logic [3:0] CMD_IORD = 4'b0101;
  localparam logic [3:0] CMD_IOWR = 4'b0110;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] addr_q, addr_d;
  logic [3:0]  cmd_q, cmd_d;
  logic        ube_q, ube_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] dout_q, dout_d;
  logic [7:0]  io_q [16];
  logic [7:0]  io_d [16];
  logic [15:0] mem_q [2**MEM_ADDR_BITS];

  logic        capture;
  logic        enter_ack;
  logic        commit;
  logic [19:0] eff_addr;
  logic [3:0]  eff_cmd;
  logic [15:0] rd_val;
  logic [15:0] mem_rd;
  logic [MEM_ADDR_BITS-1:0] rd_idx;
  logic [MEM_ADDR_BITS-1:0] wr_idx;
  logic        mem_we;
  logic        unused_addr_bits;

  assign capture   = (state_q == S_IDLE) && (bus_status != CMD_IDLE);
  assign commit    = (state_q == S_ACK);
  assign enter_ack = (state_d == S_ACK) && (state_q != S_ACK);

  // With zero wait states ACK is entered on the capture edge itself, so the read
  // path must look at the live bus rather than the not-yet-latched copy.
  assign eff_addr = capture ? address_in : addr_q;
  assign eff_cmd  = capture ? bus_status : cmd_q;
  assign rd_idx   = eff_addr[MEM_ADDR_BITS:1];
  assign wr_idx   = addr_q[MEM_ADDR_BITS:1];
  assign mem_rd   = mem_q[rd_idx];
  assign mem_we   = commit && (cmd_q == CMD_MWR);
  assign unused_addr_bits = ^eff_addr;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 20'd0;
      cmd_q   <= CMD_IDLE;
      ube_q   <= 1'b0;
      wdata_q <= 16'd0;
      dout_q  <= 16'd0;
      for (int i = 0; i < 16; i++) io_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      ube_q   <= ube_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      for (int i = 0; i < 16; i++) io_q[i] <= io_d[i];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          if (WAIT_STATES == 0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Transaction latch, read mux and IO register updates
  always_comb begin
    addr_d  = capture ? address_in : addr_q;
    cmd_d   = capture ? bus_status : cmd_q;
    ube_d   = capture ? bus_upper_byte_enable : ube_q;
    wdata_d = capture ? data_in : wdata_q;

    rd_val = 16'hffff;
    case (eff_cmd)
      CMD_MRD, CMD_MWR: rd_val = mem_rd;
      CMD_IORD, CMD_IOWR: begin
        if (eff_addr[15:4] == 12'd0)
          rd_val = {io_q[{eff_addr[3:1], 1'b1}], io_q[{eff_addr[3:1], 1'b0}]};
      end
      default: rd_val = 16'hffff;
    endcase
    dout_d = enter_ack ? rd_val : dout_q;

    for (int i = 0; i < 16; i++) io_d[i] = io_q[i];
    if (commit && (cmd_q == CMD_IOWR) && (addr_q[15:4] == 12'd0)) begin
      if (!addr_q[0]) io_d[{addr_q[3:1], 1'b0}] = wdata_q[7:0];
      if (ube_q)      io_d[{addr_q[3:1], 1'b1}] = wdata_q[15:8];
    end
  end

  // RAM is deliberately outside the reset domain so its contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (!addr_q[0]) mem_q[wr_idx][7:0]  <= wdata_q[7:0];
      if (ube_q)      mem_q[wr_idx][15:8] <= wdata_q[15:8];
    end
  end

  // Outputs
  always_comb begin
    readyb    = (state_q != S_ACK);
    data_out  = dout_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_v30mz_bus_responder.sv
// Directed bench for v30mz_bus_responder: one instance with one wait state and one
// with zero wait states for back-to-back timing.
module tb_v30mz_bus_responder;

  localparam int WS = 1;

  logic        clk;
  logic        reset;
  logic [19:0] address_in;
  logic [3:0]  bus_status;
  logic        bus_upper_byte_enable;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        readyb;
  logic [1:0]  state_dbg;
  logic [15:0] data_out0;
  logic        readyb0;
  logic [1:0]  state_dbg0;

  int checks;
  int passes;

  v30mz_bus_responder #(.WAIT_STATES(WS), .MEM_ADDR_BITS(12)) dut (
    .clk(clk), .reset(reset), .address_in(address_in), .bus_status(bus_status),
    .bus_upper_byte_enable(bus_upper_byte_enable), .data_in(data_in),
    .data_out(data_out), .readyb(readyb), .state_dbg(state_dbg)
  );

  v30mz_bus_responder #(.WAIT_STATES(0), .MEM_ADDR_BITS(12)) dut0 (
    .clk(clk), .reset(reset), .address_in(address_in), .bus_status(bus_status),
    .bus_upper_byte_enable(bus_upper_byte_enable), .data_in(data_in),
    .data_out(data_out0), .readyb(readyb0), .state_dbg(state_dbg0)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Starts just after a negedge, ends on the negedge after the readyb pulse.
  task automatic txn(input string tag, input logic [3:0] cmd, input logic [19:0] addr,
                     input logic ube, input logic [15:0] wd, input bit chk_rd,
                     input logic [15:0] exp_rd);
    int lat;
    bit seen;
    bus_status = cmd;
    address_in = addr;
    bus_upper_byte_enable = ube;
    data_in = wd;
    @(posedge clk);
    #1;
    bus_status = 4'hf;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (readyb == 1'b0) seen = 1'b1;
    end
    check({tag, "_lat"}, lat, WS + 1);
    if (chk_rd) check({tag, "_data"}, data_out, {16'd0, exp_rd});
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, readyb}, 32'd1);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    reset = 1'b0;
    address_in = 20'd0;
    bus_status = 4'hf;
    bus_upper_byte_enable = 1'b0;
    data_in = 16'd0;

    #2;
    check("rst_readyb", {31'd0, readyb}, 32'd1);
    check("rst_dout", {16'd0, data_out}, 32'h0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_readyb", {31'd0, readyb}, 32'd1);

    // Word write then read
    txn("wr_beef", 4'b1010, 20'h00100, 1'b1, 16'hbeef, 1'b0, 16'h0);
    txn("rd_beef", 4'b1001, 20'h00100, 1'b1, 16'h0, 1'b1, 16'hbeef);

    // Byte lanes
    txn("wr_1234", 4'b1010, 20'h00200, 1'b1, 16'h1234, 1'b0, 16'h0);
    txn("wr_ab_hi", 4'b1010, 20'h00201, 1'b1, 16'hab00, 1'b0, 16'h0);
    txn("rd_ab34", 4'b1001, 20'h00200, 1'b1, 16'h0, 1'b1, 16'hab34);
    txn("wr_cd_lo", 4'b1010, 20'h00200, 1'b0, 16'h00cd, 1'b0, 16'h0);
    txn("rd_abcd", 4'b1001, 20'h00200, 1'b0, 16'h0, 1'b1, 16'habcd);
    // Bits above the RAM index alias back onto the same word
    txn("rd_alias", 4'b1001, 20'h82200, 1'b1, 16'h0, 1'b1, 16'habcd);

    // IO space
    txn("io_wr_p3", 4'b0110, 20'h00003, 1'b1, 16'h5a00, 1'b0, 16'h0);
    txn("io_rd_p3", 4'b0101, 20'h00003, 1'b1, 16'h0, 1'b1, 16'h5a00);
    txn("io_wr_hi", 4'b0110, 20'h00012, 1'b1, 16'h7777, 1'b0, 16'h0);
    txn("io_rd_hi", 4'b0101, 20'h00010, 1'b1, 16'h0, 1'b1, 16'hffff);
    txn("io_rd_p2", 4'b0101, 20'h00002, 1'b1, 16'h0, 1'b1, 16'h5a00);
    @(negedge clk);
    check("dout_hold", {16'd0, data_out}, 32'h5a00);

    // Unknown command
    txn("unk", 4'b0000, 20'h00100, 1'b1, 16'h1111, 1'b1, 16'hffff);
    txn("unk_ram", 4'b1001, 20'h00100, 1'b1, 16'h0, 1'b1, 16'hbeef);

    // Reset during the wait state of a write
    txn("wr_2222", 4'b1010, 20'h00300, 1'b1, 16'h2222, 1'b0, 16'h0);
    txn("rd_2222", 4'b1001, 20'h00300, 1'b1, 16'h0, 1'b1, 16'h2222);
    bus_status = 4'b1010;
    address_in = 20'h00300;
    bus_upper_byte_enable = 1'b1;
    data_in = 16'h1111;
    @(posedge clk);
    #1;
    bus_status = 4'hf;
    check("mid_wait_state", {30'd0, state_dbg}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_readyb", {31'd0, readyb}, 32'd1);
    check("mid_rst_dout", {16'd0, data_out}, 32'h0);
    check("mid_rst_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    txn("rd_after_rst", 4'b1001, 20'h00300, 1'b1, 16'h0, 1'b1, 16'h2222);
    txn("io_after_rst", 4'b0101, 20'h00003, 1'b1, 16'h0, 1'b1, 16'h0000);

    // Back-to-back on the zero-wait instance: pulse after every odd edge
    bus_status = 4'b1001;
    address_in = 20'h00100;
    bus_upper_byte_enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b_%0d", k), {31'd0, readyb0}, (k % 2 == 1) ? 32'd0 : 32'd1);
    end
    bus_status = 4'hf;
    check("b2b_data", {16'd0, data_out0}, 32'hbeef);
    for (int k = 0; k < 4; k++) @(negedge clk);
    check("b2b_ws1_data", {16'd0, data_out}, 32'hbeef);
    check("b2b_ws1_idle", {30'd0, state_dbg}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
